// File: rtl/hall_emulator_module.sv
// Three-phase 120-degree Hall pattern generator driven by a sector period and direction.
// Optional fault injection on the Hall outputs: define HALL_FAULT_INJECT_EN.
module hall_emulator_module #(
    parameter int unsigned PERIOD_W    = 24,
    parameter int unsigned INIT_SECTOR = 0
) (
    input  logic                sys_clk,
    input  logic                reset_n,
    input  logic                enable_in,
    input  logic                dir_in,
    input  logic [PERIOD_W-1:0] period_in,
`ifdef HALL_FAULT_INJECT_EN
    input  logic [1:0]          fault_in,
`endif
    output logic                hall_u_out,
    output logic                hall_v_out,
    output logic                hall_w_out,
    output logic [2:0]          sector_out,
    output logic                sector_tick_out
);

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    localparam logic [2:0]          INIT_SEC = 3'(INIT_SECTOR);
    localparam logic [PERIOD_W-1:0] MIN_PER  = PERIOD_W'(2);

    function automatic logic [2:0] sector_code(input logic [2:0] s);
        case (s)
            3'd0:    sector_code = 3'b101;
            3'd1:    sector_code = 3'b100;
            3'd2:    sector_code = 3'b110;
            3'd3:    sector_code = 3'b010;
            3'd4:    sector_code = 3'b011;
            3'd5:    sector_code = 3'b001;
            default: sector_code = 3'b101;
        endcase
    endfunction

    function automatic logic [PERIOD_W-1:0] clamp_period(input logic [PERIOD_W-1:0] p);
        clamp_period = (p < MIN_PER) ? MIN_PER : p;
    endfunction

    state_t              state_q, state_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic [PERIOD_W-1:0] per_q, per_d;
    logic [2:0]          sector_q, sector_d;
    logic [2:0]          hall_q, hall_d;
    logic                tick_q, tick_d;
    logic [2:0]          sector_fwd, sector_rev;

    always_comb begin
        sector_fwd = (sector_q == 3'd5) ? 3'd0 : sector_q + 3'd1;
        sector_rev = (sector_q == 3'd0) ? 3'd5 : sector_q - 3'd1;

        state_d  = state_q;
        cnt_d    = cnt_q;
        per_d    = per_q;
        sector_d = sector_q;
        tick_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (enable_in) begin
                    state_d = ST_RUN;
                    per_d   = clamp_period(period_in);
                end
            end
            ST_RUN: begin
                if (!enable_in) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == per_q - PERIOD_W'(1)) begin
                    // Direction is taken live at the boundary so a reversal applies to this step.
                    cnt_d    = '0;
                    tick_d   = 1'b1;
                    per_d    = clamp_period(period_in);
                    sector_d = dir_in ? sector_fwd : sector_rev;
                end else begin
                    cnt_d = cnt_q + PERIOD_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        hall_d = sector_code(sector_d);
`ifdef HALL_FAULT_INJECT_EN
        case (fault_in)
            2'b01:   hall_d = '0;
            2'b10:   hall_d = '1;
            2'b11:   hall_d = hall_q;
            default: hall_d = sector_code(sector_d);
        endcase
`endif
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            per_q    <= MIN_PER;
            sector_q <= INIT_SEC;
            hall_q   <= sector_code(INIT_SEC);
            tick_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            per_q    <= per_d;
            sector_q <= sector_d;
            hall_q   <= hall_d;
            tick_q   <= tick_d;
        end
    end

    assign hall_u_out      = hall_q[2];
    assign hall_v_out      = hall_q[1];
    assign hall_w_out      = hall_q[0];
    assign sector_out      = sector_q;
    assign sector_tick_out = tick_q;

endmodule

// File: tb/tb_hall_emulator_module.sv
// Scoreboard bench for hall_emulator_module: stimulus queues expected steps, monitor checks them.
module tb_hall_emulator_module;

    localparam int unsigned PW = 24;

    logic          sys_clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          enable_in = 1'b0;
    logic          dir_in = 1'b1;
    logic [PW-1:0] period_in = 24'd10;
    logic          hall_u_out, hall_v_out, hall_w_out;
    logic [2:0]    sector_out;
    logic          sector_tick_out;
    logic [2:0]    hall;
`ifdef HALL_FAULT_INJECT_EN
    logic [1:0]    fault_in = 2'b00;
    logic [1:0]    flt_reg;
`endif

    hall_emulator_module #(.PERIOD_W(PW), .INIT_SECTOR(0)) dut (
        .sys_clk         (sys_clk),
        .reset_n         (reset_n),
        .enable_in       (enable_in),
        .dir_in          (dir_in),
        .period_in       (period_in),
`ifdef HALL_FAULT_INJECT_EN
        .fault_in        (fault_in),
`endif
        .hall_u_out      (hall_u_out),
        .hall_v_out      (hall_v_out),
        .hall_w_out      (hall_w_out),
        .sector_out      (sector_out),
        .sector_tick_out (sector_tick_out)
    );

    assign hall = {hall_u_out, hall_v_out, hall_w_out};

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

`ifdef HALL_FAULT_INJECT_EN
    always @(posedge sys_clk or negedge reset_n)
        if (!reset_n) flt_reg <= 2'b00;
        else          flt_reg <= fault_in;
`endif

    typedef struct {
        int         cyc;
        logic [2:0] sec;
        logic [2:0] hall;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    logic [2:0] cur_sec  = 3'd0;
    logic [2:0] cur_hall = 3'b101;

    task automatic push(input int c, input logic [2:0] s, input logic [2:0] h);
        exp_t e;
        e.cyc = c; e.sec = s; e.hall = h;
        sb.push_back(e);
    endtask

    task automatic go(input int c);
        while (cyc < c) @(negedge sys_clk);
    endtask

    // Monitor: a tick is the "output valid"; between ticks outputs must hold.
    initial begin : monitor
        exp_t       e;
        logic       bad;
        logic [2:0] eh;
        forever begin
            @(negedge sys_clk or negedge reset_n);
            #1;
            checks++;
            bad = 1'b0;
            if (!reset_n) begin
                cur_sec  = 3'd0;
                cur_hall = 3'b101;
                if (sector_tick_out !== 1'b0 || sector_out !== 3'd0 || hall !== 3'b101) begin
                    bad = 1'b1;
                    $display("FAIL reset: tick=%b sector=%0d hall=%b, required tick=0 sector=0 hall=101",
                             sector_tick_out, sector_out, hall);
                end
            end else begin
                if (sector_tick_out === 1'b1) begin
                    if (sb.size() == 0) begin
                        bad = 1'b1;
                        $display("FAIL unexpected_tick: tick at cycle %0d sector=%0d, required no tick",
                                 cyc, sector_out);
                    end else begin
                        e = sb.pop_front();
                        cur_sec  = e.sec;
                        cur_hall = e.hall;
                        if (e.cyc != cyc) begin
                            bad = 1'b1;
                            $display("FAIL tick_time: tick at cycle %0d, required cycle %0d", cyc, e.cyc);
                        end
                    end
                end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
                    e = sb.pop_front();
                    cur_sec  = e.sec;
                    cur_hall = e.hall;
                    bad = 1'b1;
                    $display("FAIL missing_tick: no tick by cycle %0d, required tick at cycle %0d to sector %0d",
                             cyc, e.cyc, e.sec);
                end
                eh = cur_hall;
`ifdef HALL_FAULT_INJECT_EN
                if (flt_reg == 2'b10)      eh = 3'b111;
                else if (flt_reg == 2'b01) eh = 3'b000;
`endif
                if (sector_out !== cur_sec || hall !== eh) begin
                    bad = 1'b1;
                    $display("FAIL outputs: cycle %0d sector=%0d hall=%b, required sector=%0d hall=%b",
                             cyc, sector_out, hall, cur_sec, eh);
                end
            end
            if (bad) errors++;
        end
    end

    initial begin : stimulus
        int n, t, n2;
`ifdef HALL_FAULT_INJECT_EN
        int n3;
`endif
        repeat (3) @(negedge sys_clk);
        reset_n = 1'b1;
        repeat (50) @(negedge sys_clk);

        // Forward, period 10, full revolution.
        n = cyc;
        enable_in = 1'b1; dir_in = 1'b1; period_in = 24'd10;
        push(n + 11, 3'd1, 3'b100);
        push(n + 21, 3'd2, 3'b110);
        push(n + 31, 3'd3, 3'b010);
        push(n + 41, 3'd4, 3'b011);
        push(n + 51, 3'd5, 3'b001);
        push(n + 61, 3'd0, 3'b101);
        go(n + 61);

        // Reverse, period 4 (current sector finishes at 10).
        dir_in = 1'b0; period_in = 24'd4;
        push(n + 71, 3'd5, 3'b001);
        push(n + 75, 3'd4, 3'b011);
        push(n + 79, 3'd3, 3'b010);
        push(n + 83, 3'd2, 3'b110);
        push(n + 87, 3'd1, 3'b100);
        push(n + 91, 3'd0, 3'b101);
        t = n + 91;
        go(t);

        // Mid-sector period changes only apply at the next boundary.
        dir_in = 1'b1; period_in = 24'd10;
        push(t + 4, 3'd1, 3'b100);
        go(t + 7);
        period_in = 24'd20;
        push(t + 14, 3'd2, 3'b110);
        push(t + 34, 3'd3, 3'b010);
        go(t + 19);
        period_in = 24'd0;
        push(t + 36, 3'd4, 3'b011);
        push(t + 38, 3'd5, 3'b001);
        go(t + 38);
        period_in = 24'd1;
        push(t + 40, 3'd0, 3'b101);
        push(t + 42, 3'd1, 3'b100);
        go(t + 42);
        period_in = 24'd4;
        push(t + 44, 3'd2, 3'b110);
        push(t + 48, 3'd3, 3'b010);
        push(t + 52, 3'd4, 3'b011);

        // Direction reversed exactly at the boundary: 4 -> 3.
        go(t + 55);
        dir_in = 1'b0;
        push(t + 56, 3'd3, 3'b010);

        // Enable drops on the terminal-count cycle: no step.
        go(t + 59);
        enable_in = 1'b0;
        go(t + 70);
        enable_in = 1'b1; dir_in = 1'b1; period_in = 24'd3;
        push(t + 74, 3'd4, 3'b011);
        push(t + 77, 3'd5, 3'b001);
        go(t + 77);
        period_in = 24'd8;
        push(t + 80, 3'd0, 3'b101);
        push(t + 88, 3'd1, 3'b100);
        push(t + 96, 3'd2, 3'b110);

        // Asynchronous reset at clock 5 of sector 2.
        go(t + 101);
        #2;
        reset_n = 1'b0;
        sb.delete();
        @(negedge sys_clk);
        enable_in = 1'b0;
        reset_n = 1'b1;
        repeat (5) @(negedge sys_clk);

        n2 = cyc;
        enable_in = 1'b1; dir_in = 1'b1; period_in = 24'd2;
        push(n2 + 3, 3'd1, 3'b100);
        push(n2 + 5, 3'd2, 3'b110);
        go(n2 + 5);
        enable_in = 1'b0;
        repeat (5) @(negedge sys_clk);

`ifdef HALL_FAULT_INJECT_EN
        n3 = cyc;
        fault_in = 2'b10; enable_in = 1'b1; period_in = 24'd2;
        push(n3 + 3, 3'd3, 3'b010);
        push(n3 + 5, 3'd4, 3'b011);
        push(n3 + 7, 3'd5, 3'b001);
        go(n3 + 7);
        fault_in = 2'b00;
        go(n3 + 8);
        enable_in = 1'b0;
        repeat (5) @(negedge sys_clk);
`endif

        repeat (2) @(negedge sys_clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL leftover: %0d expected ticks never seen, required 0", sb.size());
        end
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
